// File: rtl/rom_pkg.sv
// Shared types and constants for the ROM initiator and its bus interface.
package rom_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 8;
    localparam int unsigned DEF_ADDR_WIDTH = 3;
    localparam int unsigned READ_LATENCY   = 1;

    typedef enum logic [2:0] {
        IDLE,
        READ,
        WAIT,
        PRESENT,
        FINISH
    } state_t;

endpackage

// File: rtl/rom_reader_if.sv
// ROM read port plus valid/ready output stream; master is the reader, slave is ROM + consumer.
interface rom_reader_if
    import rom_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
);

    logic                  rom_en;
    logic [ADDR_WIDTH-1:0] rom_addr;
    logic [DATA_WIDTH-1:0] rom_data;
    logic [DATA_WIDTH-1:0] out_data;
    logic                  out_valid;
    logic                  out_ready;
    logic                  out_last;

    modport master (
        output rom_en,
        output rom_addr,
        input  rom_data,
        output out_data,
        output out_valid,
        input  out_ready,
        output out_last
    );

    modport slave (
        input  rom_en,
        input  rom_addr,
        output rom_data,
        input  out_data,
        input  out_valid,
        output out_ready,
        input  out_last
    );

endinterface

// File: rtl/rom_reader.sv
// Walks a run of ROM addresses (wrapping), hides the registered read latency and
// streams each word out on valid/ready with a last marker and a done pulse.
module rom_reader
    import rom_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] start_addr,
    input  logic [ADDR_WIDTH:0]   length,
    output logic                  busy,
    output logic                  done,
    rom_reader_if.master          bus
);

    localparam int unsigned LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [ADDR_WIDTH:0] REM_ONE = {{ADDR_WIDTH{1'b0}}, 1'b1};

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [ADDR_WIDTH:0]   remaining;
    logic [LAT_W-1:0]      lat;

    always_ff @(posedge clock) begin
        if (reset) begin
            state         <= IDLE;
            cur_addr      <= '0;
            remaining     <= '0;
            lat           <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            bus.rom_en    <= 1'b0;
            bus.rom_addr  <= '0;
            bus.out_data  <= '0;
            bus.out_valid <= 1'b0;
            bus.out_last  <= 1'b0;
        end else begin
            done <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (length != '0) begin
                            cur_addr     <= start_addr;
                            remaining    <= length;
                            bus.rom_en   <= 1'b1;
                            bus.rom_addr <= start_addr;
                            state        <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                READ: begin
                    bus.rom_en <= 1'b0;
                    lat        <= LAT_W'(READ_LATENCY - 1);
                    state      <= WAIT;
                end
                WAIT: begin
                    // Capture once the ROM's registered output has caught up.
                    if (lat == '0) begin
                        bus.out_data  <= bus.rom_data;
                        bus.out_valid <= 1'b1;
                        bus.out_last  <= (remaining == REM_ONE);
                        state         <= PRESENT;
                    end else begin
                        lat <= lat - LAT_W'(1);
                    end
                end
                PRESENT: begin
                    if (bus.out_ready) begin
                        bus.out_valid <= 1'b0;
                        bus.out_last  <= 1'b0;
                        remaining     <= remaining - REM_ONE;
                        cur_addr      <= cur_addr + ADDR_WIDTH'(1);
                        if (remaining != REM_ONE) begin
                            bus.rom_en   <= 1'b1;
                            bus.rom_addr <= cur_addr + ADDR_WIDTH'(1);
                            state        <= READ;
                        end else begin
                            done  <= 1'b1;
                            state <= FINISH;
                        end
                    end
                end
                FINISH: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rom_reader.sv
// Bench for rom_reader: table of directed runs, random runs against a word-sequence model,
// and a mid-run reset sequence. The ROM responder returns addr+1.
module tb_rom_reader;

    localparam int DW = 8;
    localparam int AW = 3;
    localparam int DEPTH = 8;

    logic          clock;
    logic          reset;
    logic          start;
    logic [AW-1:0] start_addr;
    logic [AW:0]   length;
    logic          busy;
    logic          done;

    int vectors;
    int miscompares;

    rom_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    rom_reader #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
        .clock      (clock),
        .reset      (reset),
        .start      (start),
        .start_addr (start_addr),
        .length     (length),
        .busy       (busy),
        .done       (done),
        .bus        (bus.master)
    );

    // 8-entry synchronous-read ROM, word = addr + 1
    always @(posedge clock) begin
        if (bus.rom_en) bus.rom_data <= DW'(bus.rom_addr) + DW'(1);
    end

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int sa;
        int len;
        int stall_pct;
        int stall_word;
        int stall_cycles;
        bit mid_start;
        bit has_exp;
        int exp_first;
        int exp_last;
    } vec_t;

    vec_t tbl[6];

    function automatic int word_at(input int sa, input int i);
        return ((sa + i) % DEPTH) + 1;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all_zero();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_rom_en", bus.rom_en, 0);
        chk("rst_rom_addr", bus.rom_addr, 0);
        chk("rst_out_data", bus.out_data, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_out_last", bus.out_last, 0);
    endtask

    // Issue one run and follow it cycle by cycle until the cycle after done.
    task automatic run_one(input vec_t v);
        int  c, nreads, hs, last_hs_c, stalled, first_data, last_data;
        bit  seen_done, finished, nostall, rdy;
        nreads = 0; hs = 0; last_hs_c = 0; stalled = 0;
        first_data = 0; last_data = 0; seen_done = 0; finished = 0;
        nostall = (v.stall_pct == 0) && (v.stall_cycles == 0);
        @(negedge clock);
        start = 1'b1; start_addr = AW'(v.sa); length = (AW+1)'(v.len); bus.out_ready = 1'b1;
        @(negedge clock);
        start = 1'b0;
        c = 1;
        while (!finished && c < 400) begin
            if (seen_done) begin
                chk("busy_after_done", busy, 0);
                chk("done_one_cycle", done, 0);
                finished = 1;
            end else begin
                chk("busy", busy, 1);
                if (bus.rom_en) begin
                    chk("rom_addr", bus.rom_addr, (v.sa + nreads) % DEPTH);
                    chk("valid_during_en", bus.out_valid, 0);
                    if (nostall) chk("en_timing", c, 1 + 3 * nreads);
                    nreads++;
                end
                if (bus.out_valid && hs == v.stall_word && stalled < v.stall_cycles) begin
                    rdy = 1'b0;
                    stalled++;
                end else begin
                    rdy = ($urandom_range(0, 99) >= v.stall_pct);
                end
                bus.out_ready = rdy;
                if (bus.out_valid) begin
                    chk("out_data", bus.out_data, word_at(v.sa, hs));
                    chk("out_last", bus.out_last, (hs == v.len - 1) ? 1 : 0);
                    if (nostall) chk("valid_timing", c, 3 + 3 * hs);
                    if (hs == 0) first_data = int'(bus.out_data);
                    last_data = int'(bus.out_data);
                    if (rdy) begin
                        hs++;
                        last_hs_c = c;
                    end
                end
                if (done) begin
                    chk("done_cycle", c, (v.len == 0) ? 1 : last_hs_c + 1);
                    chk("done_words", hs, v.len);
                    seen_done = 1;
                end
                if (v.mid_start && c == 4) begin
                    start = 1'b1; start_addr = 3'd5; length = 4'd1;
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clock);
            c++;
        end
        if (!finished) chk("run_timeout", 0, 1);
        chk("rom_reads", nreads, v.len);
        if (v.has_exp && v.len != 0) begin
            chk("tbl_first", first_data, v.exp_first);
            chk("tbl_last", last_data, v.exp_last);
        end
    endtask

    initial begin
        vec_t rv;
        int   k;
        vectors = 0;
        miscompares = 0;
        reset = 1'b1; start = 1'b0; start_addr = '0; length = '0; bus.out_ready = 1'b0;

        //        sa len pct sw sc mid exp first last
        tbl[0] = '{0, 8,  0, -1, 0, 0, 1, 1, 8};
        tbl[1] = '{6, 4,  0, -1, 0, 0, 1, 7, 2};
        tbl[2] = '{0, 0,  0, -1, 0, 0, 1, 0, 0};
        tbl[3] = '{2, 3,  0,  1, 5, 0, 1, 3, 5};
        tbl[4] = '{1, 4,  0, -1, 0, 1, 1, 2, 5};
        tbl[5] = '{5, 12, 0, -1, 0, 0, 1, 6, 1};

        repeat (2) @(negedge clock);
        chk_all_zero();
        reset = 1'b0;

        for (int i = 0; i < 6; i++) run_one(tbl[i]);

        for (int i = 0; i < 20; i++) begin
            rv = '{int'($urandom_range(0, 7)), int'($urandom_range(0, 15)), 40, -1, 0, 0, 0, 0, 0};
            run_one(rv);
            repeat ($urandom_range(0, 3)) @(negedge clock);
        end

        // Reset while a word is held in PRESENT, then a clean run afterwards.
        @(negedge clock);
        bus.out_ready = 1'b0;
        start = 1'b1; start_addr = 3'd0; length = 4'd8;
        @(negedge clock);
        start = 1'b0;
        k = 0;
        while (!bus.out_valid && k < 10) begin
            @(negedge clock);
            k++;
        end
        chk("reach_present", bus.out_valid, 1);
        reset = 1'b1;
        @(negedge clock);
        chk_all_zero();
        reset = 1'b0;
        rv = '{3, 2, 0, -1, 0, 0, 1, 4, 5};
        run_one(rv);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
